// File: rtl/common_pkg.sv
// Shared RV32IC types, opcode constants and helpers used by the fetch/decode front end.
package common_pkg;

  typedef logic [31:0] instruction_t;
  typedef logic [15:0] halfword_t;

  localparam logic [1:0] OPC_UNCOMPRESSED = 2'b11;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam instruction_t INSTR_EBREAK = 32'h0010_0073;

  function automatic logic is_compressed(halfword_t h);
    return h[1:0] != OPC_UNCOMPRESSED;
  endfunction

endpackage

// File: rtl/decompressor.sv
// Expands an RV32C halfword into its 32-bit RV32I equivalent; 32-bit inputs pass through.
// Reserved or illegal compressed encodings expand to all-zeros, itself an illegal instruction.
module decompressor
  import common_pkg::*;
(
  input  logic [31:0]  raw,
  output instruction_t instr
);

  halfword_t  c;
  logic [4:0] rd;
  logic [4:0] rs2;
  logic [4:0] rdp;
  logic [4:0] rs1p;

  assign c    = raw[15:0];
  assign rd   = c[11:7];
  assign rs2  = c[6:2];
  assign rdp  = {2'b01, c[4:2]};
  assign rs1p = {2'b01, c[9:7]};

  always_comb begin
    instr = '0;
    if (raw[1:0] == OPC_UNCOMPRESSED) begin
      instr = raw;
    end else begin
      case (c[1:0])
        2'b00: begin
          case (c[15:13])
            3'b000: begin
              if (c[12:5] != 8'h00) begin
                instr = {2'b00, c[10:7], c[12:11], c[5], c[6], 2'b00, 5'd2, 3'b000, rdp,
                         OPC_OP_IMM};
              end
            end
            3'b010: instr = {5'b0, c[5], c[12:10], c[6], 2'b00, rs1p, 3'b010, rdp, OPC_LOAD};
            3'b110: instr = {5'b0, c[5], c[12], rdp, rs1p, 3'b010, c[11:10], c[6], 2'b00,
                             OPC_STORE};
            default: instr = '0;
          endcase
        end
        2'b01: begin
          case (c[15:13])
            3'b000: instr = {{7{c[12]}}, c[6:2], rd, 3'b000, rd, OPC_OP_IMM};
            3'b001: instr = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], c[12],
                             {8{c[12]}}, 5'd1, OPC_JAL};
            3'b010: instr = {{7{c[12]}}, c[6:2], 5'd0, 3'b000, rd, OPC_OP_IMM};
            3'b011: begin
              if (rd == 5'd2) begin
                if ({c[12], c[6:2]} != 6'd0) begin
                  instr = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0000, 5'd2, 3'b000, 5'd2,
                           OPC_OP_IMM};
                end
              end else if ({c[12], c[6:2]} != 6'd0) begin
                instr = {{15{c[12]}}, c[6:2], rd, OPC_LUI};
              end
            end
            3'b100: begin
              case (c[11:10])
                2'b00: if (!c[12]) instr = {7'b0000000, c[6:2], rs1p, 3'b101, rs1p, OPC_OP_IMM};
                2'b01: if (!c[12]) instr = {7'b0100000, c[6:2], rs1p, 3'b101, rs1p, OPC_OP_IMM};
                2'b10: instr = {{7{c[12]}}, c[6:2], rs1p, 3'b111, rs1p, OPC_OP_IMM};
                default: begin
                  if (!c[12]) begin
                    case (c[6:5])
                      2'b00:   instr = {7'b0100000, rdp, rs1p, 3'b000, rs1p, OPC_OP};
                      2'b01:   instr = {7'b0000000, rdp, rs1p, 3'b100, rs1p, OPC_OP};
                      2'b10:   instr = {7'b0000000, rdp, rs1p, 3'b110, rs1p, OPC_OP};
                      default: instr = {7'b0000000, rdp, rs1p, 3'b111, rs1p, OPC_OP};
                    endcase
                  end
                end
              endcase
            end
            3'b101: instr = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], c[12],
                             {8{c[12]}}, 5'd0, OPC_JAL};
            3'b110: instr = {c[12], {3{c[12]}}, c[6:5], c[2], 5'd0, rs1p, 3'b000, c[11:10],
                             c[4:3], c[12], OPC_BRANCH};
            default: instr = {c[12], {3{c[12]}}, c[6:5], c[2], 5'd0, rs1p, 3'b001, c[11:10],
                              c[4:3], c[12], OPC_BRANCH};
          endcase
        end
        default: begin
          case (c[15:13])
            3'b000: if (!c[12]) instr = {7'b0000000, c[6:2], rd, 3'b001, rd, OPC_OP_IMM};
            3'b010: begin
              if (rd != 5'd0) begin
                instr = {4'b0000, c[3:2], c[12], c[6:4], 2'b00, 5'd2, 3'b010, rd, OPC_LOAD};
              end
            end
            3'b100: begin
              if (!c[12]) begin
                if (rs2 == 5'd0) begin
                  if (rd != 5'd0) instr = {12'h000, rd, 3'b000, 5'd0, OPC_JALR};
                end else begin
                  instr = {7'b0000000, rs2, 5'd0, 3'b000, rd, OPC_OP};
                end
              end else begin
                if (rs2 == 5'd0) begin
                  instr = (rd == 5'd0) ? INSTR_EBREAK : {12'h000, rd, 3'b000, 5'd1, OPC_JALR};
                end else begin
                  instr = {7'b0000000, rs2, rd, 3'b000, rd, OPC_OP};
                end
              end
            end
            3'b110: instr = {4'b0000, c[8:7], c[12], rs2, 5'd2, 3'b010, c[11:9], 2'b00,
                             OPC_STORE};
            default: instr = '0;
          endcase
        end
      endcase
    end
  end

endmodule

// File: rtl/fetch_aligner.sv
// Splits word-aligned fetch data into RV32IC instructions (including word-straddling ones),
// expands them through the decompressor, and sequences the fetch address and PC redirects.
module fetch_aligner
  import common_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset_n,
  output logic [31:0]  fetch_addr,
  input  logic         fetch_valid,
  input  logic [31:0]  fetch_data,
  output logic         fetch_ready,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  output logic         dec_valid,
  input  logic         dec_ready,
  output instruction_t dec_instr,
  output logic [31:0]  dec_raw,
  output logic         dec_compressed,
  output logic [31:0]  dec_pc
);

  halfword_t   hb_q [3];
  halfword_t   hb_d [3];
  logic [1:0]  count_q, count_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_addr_q, fetch_addr_d;
  logic        drop_half_q, drop_half_d;

  logic        compressed;
  logic        avail;
  logic        fire;
  logic        accept;
  logic [1:0]  consumed;
  logic [1:0]  remaining;

  // Halfword alignment comes from redirect_pc[1]; bit 0 carries no information.
  logic        unused_redirect_lsb;
  assign unused_redirect_lsb = redirect_pc[0];

  always_comb begin
    compressed     = is_compressed(hb_q[0]);
    avail          = compressed ? (count_q >= 2'd1) : (count_q >= 2'd2);
    dec_valid      = avail && !redirect_valid;
    fire           = dec_valid && dec_ready;
    consumed       = fire ? (compressed ? 2'd1 : 2'd2) : 2'd0;
    remaining      = count_q - consumed;
    // At most one halfword left after this cycle's consume leaves room for a full word.
    fetch_ready    = (remaining <= 2'd1) && !redirect_valid;
    accept         = fetch_valid && fetch_ready;
    dec_raw        = compressed ? {16'h0000, hb_q[0]} : {hb_q[1], hb_q[0]};
    dec_compressed = compressed;
    dec_pc         = pc_q;
    fetch_addr     = fetch_addr_q;
  end

  always_comb begin
    hb_d         = hb_q;
    count_d      = remaining;
    pc_d         = pc_q;
    fetch_addr_d = fetch_addr_q;
    drop_half_d  = drop_half_q;

    case (consumed)
      2'd1: begin
        hb_d[0] = hb_q[1];
        hb_d[1] = hb_q[2];
      end
      2'd2: hb_d[0] = hb_q[2];
      default: ;
    endcase

    if (fire) begin
      pc_d = pc_q + (compressed ? 32'd2 : 32'd4);
    end

    if (accept) begin
      fetch_addr_d = fetch_addr_q + 32'd4;
      if (drop_half_q) begin
        drop_half_d = 1'b0;
        count_d     = remaining + 2'd1;
        if (remaining == 2'd0) begin
          hb_d[0] = fetch_data[31:16];
        end else begin
          hb_d[1] = fetch_data[31:16];
        end
      end else begin
        count_d = remaining + 2'd2;
        if (remaining == 2'd0) begin
          hb_d[0] = fetch_data[15:0];
          hb_d[1] = fetch_data[31:16];
        end else begin
          hb_d[1] = fetch_data[15:0];
          hb_d[2] = fetch_data[31:16];
        end
      end
    end

    if (redirect_valid) begin
      count_d      = 2'd0;
      pc_d         = {redirect_pc[31:1], 1'b0};
      fetch_addr_d = {redirect_pc[31:2], 2'b00};
      drop_half_d  = redirect_pc[1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hb_q[0]      <= '0;
      hb_q[1]      <= '0;
      hb_q[2]      <= '0;
      count_q      <= 2'd0;
      pc_q         <= RESET_PC;
      fetch_addr_q <= {RESET_PC[31:2], 2'b00};
      drop_half_q  <= RESET_PC[1];
    end else begin
      hb_q         <= hb_d;
      count_q      <= count_d;
      pc_q         <= pc_d;
      fetch_addr_q <= fetch_addr_d;
      drop_half_q  <= drop_half_d;
    end
  end

  decompressor u_decompressor (
    .raw   (dec_raw),
    .instr (dec_instr)
  );

endmodule

// File: tb/tb_fetch_aligner.sv
// Directed and randomized bench for fetch_aligner against an instruction-stream model.
module tb_fetch_aligner;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] raw;
    logic [31:0] instr;
    logic        comp;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic [31:0] fetch_addr;
  logic        fetch_valid;
  logic [31:0] fetch_data;
  logic        fetch_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_raw;
  logic        dec_compressed;
  logic [31:0] dec_pc;

  logic [31:0] mem [512];
  logic [31:0] mem_end;
  exp_t        exp_q [$];
  int          checks;
  int          errors;
  logic        obs_valid;
  logic        obs_fready;

  fetch_aligner #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .fetch_addr     (fetch_addr),
    .fetch_valid    (fetch_valid),
    .fetch_data     (fetch_data),
    .fetch_ready    (fetch_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_raw        (dec_raw),
    .dec_compressed (dec_compressed),
    .dec_pc         (dec_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_add(input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
    return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  task automatic put_half(input logic [31:0] a, input logic [15:0] h);
    if (a[1]) mem[a[10:2]][31:16] = h;
    else      mem[a[10:2]][15:0]  = h;
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] raw,
                          input logic [31:0] instr, input logic comp);
    exp_t e;
    e.pc = pc; e.raw = raw; e.instr = instr; e.comp = comp;
    exp_q.push_back(e);
  endtask

  // Builds a program of known instructions in memory and the stream decode must observe.
  task automatic gen_prog(input logic [31:0] start, input int n, input bit only32);
    logic [31:0] pc, w;
    logic [15:0] h;
    logic [5:0]  imm;
    logic [4:0]  rd, rs2, off;
    logic [2:0]  rdp, rs1p;
    int          k;
    pc = start;
    for (int i = 0; i < n; i++) begin
      k    = only32 ? 0 : $urandom_range(0, 5);
      rd   = 5'($urandom_range(1, 31));
      rs2  = 5'($urandom_range(1, 31));
      imm  = 6'($urandom_range(0, 63));
      rdp  = 3'($urandom_range(0, 7));
      rs1p = 3'($urandom_range(0, 7));
      off  = 5'($urandom_range(0, 31));
      if (k == 0) begin
        w = $urandom;
        w[1:0] = 2'b11;
        put_half(pc, w[15:0]);
        put_half(pc + 32'd2, w[31:16]);
        push_exp(pc, w, w, 1'b0);
        pc += 32'd4;
      end else begin
        case (k)
          1: begin  // c.li rd, imm
            h = {3'b010, imm[5], rd, imm[4:0], 2'b01};
            w = enc_i({{6{imm[5]}}, imm}, 5'd0, 3'b000, rd, 7'b0010011);
          end
          2: begin  // c.addi rd, imm
            if (imm == 6'd0) imm = 6'd1;
            h = {3'b000, imm[5], rd, imm[4:0], 2'b01};
            w = enc_i({{6{imm[5]}}, imm}, rd, 3'b000, rd, 7'b0010011);
          end
          3: begin  // c.mv rd, rs2
            h = {4'b1000, rd, rs2, 2'b10};
            w = enc_add(rd, 5'd0, rs2);
          end
          4: begin  // c.add rd, rs2
            h = {4'b1001, rd, rs2, 2'b10};
            w = enc_add(rd, rd, rs2);
          end
          default: begin  // c.lw rd', off*4(rs1')
            h = {3'b010, off[3:1], rs1p, off[0], off[4], rdp, 2'b00};
            w = enc_i({5'b0, off, 2'b00}, {2'b01, rs1p}, 3'b010, {2'b01, rdp}, 7'b0000011);
          end
        endcase
        put_half(pc, h);
        push_exp(pc, {16'h0000, h}, w, 1'b1);
        pc += 32'd2;
      end
    end
    if (pc[1]) begin
      put_half(pc, 16'h0001);
      pc += 32'd2;
    end
    mem_end = pc;
  endtask

  // One cycle: drive the fetch source and decode, then check any presented instruction.
  task automatic step(input bit fv, input bit dr);
    exp_t e;
    @(negedge clk);
    fetch_valid = fv && (fetch_addr < mem_end);
    fetch_data  = mem[fetch_addr[10:2]];
    dec_ready   = dr;
    #1;
    obs_valid  = dec_valid;
    obs_fready = fetch_ready;
    check("addr_align", {30'b0, fetch_addr[1:0]}, 32'h0);
    if (dec_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", {31'b0, dec_valid}, 32'h0);
      end else begin
        e = exp_q[0];
        check("dec_pc", dec_pc, e.pc);
        check("dec_raw", dec_raw, e.raw);
        check("dec_instr", dec_instr, e.instr);
        check("dec_compressed", {31'b0, dec_compressed}, {31'b0, e.comp});
        if (dr) void'(exp_q.pop_front());
      end
    end
  endtask

  task automatic run_stream(input int max_cycles, input int vp, input int rp);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < max_cycles) begin
      step($urandom_range(0, 99) < vp, $urandom_range(0, 99) < rp);
      n++;
    end
    check("drain_timeout", exp_q.size(), 32'd0);
  endtask

  task automatic redirect(input logic [31:0] tgt);
    exp_q.delete();
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    fetch_valid    = 1'b1;
    fetch_data     = $urandom;
    dec_ready      = 1'b1;
    #1;
    check("redir_no_valid", {31'b0, dec_valid}, 32'h0);
    check("redir_no_fready", {31'b0, fetch_ready}, 32'h0);
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    fetch_valid    = 1'b0;
    check("redir_fetch_addr", fetch_addr, {tgt[31:2], 2'b00});
    check("redir_pc", dec_pc, {tgt[31:1], 1'b0});
    check("redir_empty", {31'b0, dec_valid}, 32'h0);
  endtask

  initial begin
    logic [31:0] start;
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    fetch_valid = 1'b0;
    fetch_data = '0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    dec_ready = 1'b0;
    mem_end = '0;
    for (int i = 0; i < 512; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("reset_valid", {31'b0, dec_valid}, 32'h0);
    check("reset_fready", {31'b0, fetch_ready}, 32'h1);
    check("reset_fetch_addr", fetch_addr, 32'h0);
    check("reset_pc", dec_pc, 32'h0);

    // Single 32-bit instruction, one cycle after accept.
    mem[0] = 32'h00A0_0093;
    mem_end = 32'h4;
    push_exp(32'h0, 32'h00A0_0093, 32'h00A0_0093, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    check("t1_latency", {31'b0, obs_valid}, 32'h1);
    check("t1_next_addr", fetch_addr, 32'h4);
    check("t1_drained", exp_q.size(), 32'd0);

    // Two compressed instructions in one word.
    redirect(32'h10);
    mem[4] = 32'h4589_4505;
    mem_end = 32'h14;
    push_exp(32'h10, 32'h0000_4505, 32'h0010_0513, 1'b1);
    push_exp(32'h12, 32'h0000_4589, 32'h0020_0593, 1'b1);
    run_stream(20, 100, 100);

    // Straddling 32-bit instruction waits for the second word.
    redirect(32'h20);
    mem[8] = 32'h0093_4505;
    mem[9] = 32'h4589_00A0;
    mem_end = 32'h24;
    push_exp(32'h20, 32'h0000_4505, 32'h0010_0513, 1'b1);
    push_exp(32'h22, 32'h00A0_0093, 32'h00A0_0093, 1'b0);
    push_exp(32'h26, 32'h0000_4589, 32'h0020_0593, 1'b1);
    repeat (4) step(1'b1, 1'b1);
    check("straddle_wait", exp_q.size(), 32'd2);
    mem_end = 32'h28;
    run_stream(20, 100, 100);

    // Back-to-back 32-bit stream, then a three-cycle decode stall.
    redirect(32'h40);
    gen_prog(32'h40, 12, 1'b1);
    step(1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1);
      check("b2b_fready", {31'b0, obs_fready}, 32'h1);
      check("b2b_valid", {31'b0, obs_valid}, 32'h1);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0);
      check("stall_valid", {31'b0, obs_valid}, 32'h1);
      check("stall_fready", {31'b0, obs_fready}, 32'h0);
    end
    run_stream(200, 100, 100);

    // Redirect to an odd halfword drops a pending 32-bit instruction.
    redirect(32'h80);
    mem[32] = 32'h00A0_0093;
    mem_end = 32'h84;
    push_exp(32'h80, 32'h00A0_0093, 32'h00A0_0093, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("pending_valid", {31'b0, obs_valid}, 32'h1);
    redirect(32'h102);
    mem[64] = 32'h4505_8067;
    mem_end = 32'h104;
    push_exp(32'h102, 32'h0000_4505, 32'h0010_0513, 1'b1);
    run_stream(20, 100, 100);
    repeat (4) step(1'b1, 1'b1);

    // Reset with three halfwords buffered.
    redirect(32'h202);
    mem[128] = 32'h4505_1234;
    mem[129] = 32'h4589_4589;
    mem_end = 32'h208;
    push_exp(32'h202, 32'h0000_4505, 32'h0010_0513, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("full_valid", {31'b0, obs_valid}, 32'h1);
    @(negedge clk);
    fetch_valid = 1'b0;
    #1;
    check("full_fready", {31'b0, fetch_ready}, 32'h0);
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("rst_mid_valid", {31'b0, dec_valid}, 32'h0);
    check("rst_mid_addr", fetch_addr, 32'h0);
    check("rst_mid_pc", dec_pc, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rst_rel_fready", {31'b0, fetch_ready}, 32'h1);
    check("rst_rel_valid", {31'b0, dec_valid}, 32'h0);
    mem_end = 32'h4;
    push_exp(32'h0, 32'h00A0_0093, 32'h00A0_0093, 1'b0);
    run_stream(20, 100, 100);

    // Randomized programs with random fetch and decode back-pressure.
    for (int r = 0; r < 8; r++) begin
      start = 32'h300 + ($urandom_range(0, 255) << 1);
      redirect(start | 32'($urandom_range(0, 1)));
      gen_prog(start, 40, 1'b0);
      run_stream(2000, 60, 60);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_aligner.md
Name: fetch_aligner

Overview:
- Sits between the instruction-fetch memory interface and decode.
- Accepts word-aligned 32-bit fetch words and splits them into a stream of RV32IC instructions, 16-bit or 32-bit, including 32-bit instructions that straddle a word boundary.
- Passes each instruction through the existing decompressor, so decode always sees a 32-bit instruction_t.
- Generates the next fetch address and handles PC redirects, including redirects to odd-halfword targets.

Parameters:
- RESET_PC, 32'h0000_0000, PC of the first instruction after reset; must be halfword-aligned.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- fetch_addr  out  32  word address of the next word to request; bits [1:0] are always 0
- fetch_valid  in  1  fetch_data holds the word at the current fetch_addr
- fetch_data  in  32  fetch word, little-endian halfwords
- fetch_ready  out  1  aligner accepts fetch_data this cycle
- redirect_valid  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  32  new PC; bit 0 is ignored
- dec_valid  out  1  dec_instr is valid
- dec_ready  in  1  decode accepts dec_instr
- dec_instr  out  instruction_t  expanded instruction from the decompressor
- dec_raw  out  32  raw bits; {16'h0, half} for compressed instructions
- dec_compressed  out  1  current instruction is 16-bit
- dec_pc  out  32  PC of dec_instr

Behaviour:
- Storage: halfword buffer hb[0:2] (48 bits), count 0..3, PC register pc, fetch_addr register.
- State drop_half (1 bit): when set, the low halfword of the next accepted word is discarded.
- Reset values: count=0, pc=RESET_PC, fetch_addr={RESET_PC[31:2],2'b00}, drop_half=RESET_PC[1], dec_valid=0, fetch_ready=1.
- Instruction detection:
  - hb[0][1:0]!=2'b11 → compressed; needs count>=1; consumes 1 halfword.
  - hb[0][1:0]==2'b11 → 32-bit; needs count>=2; consumes 2 halfwords.
- dec_valid = instruction available && !redirect_valid.
- dec_raw = compressed ? {16'h0, hb[0]} : {hb[1], hb[0]}.
- dec_instr = decompressor(dec_raw); combinational from the buffer.
- dec_pc = pc.
- Output fire (dec_valid && dec_ready):
  - buffer shifts down by the number of halfwords consumed;
  - pc += 2 for compressed, += 4 for 32-bit.
- fetch_ready = (count - consumed_this_cycle) <= 1 && !redirect_valid. This sustains one 32-bit instruction per cycle.
- Fetch accept (fetch_valid && fetch_ready):
  - append fetch_data[15:0] then fetch_data[31:16] after the remaining halfwords;
  - if drop_half is set, append only fetch_data[31:16] and clear drop_half;
  - fetch_addr += 4.
- Simultaneous accept and fire in the same cycle: shift first, then append. count_next = count - consumed + appended, which never exceeds 3.
- Latency: a word accepted at edge N produces dec_valid in the cycle after N.
- A 32-bit instruction with count==1 waits for the next word. No partial output is produced.
- Redirect has priority over everything in its cycle:
  - count←0, pc←{redirect_pc[31:1],1'b0}, fetch_addr←{redirect_pc[31:2],2'b00}, drop_half←redirect_pc[1];
  - fetch_data is ignored and no output fires.
  - The fetch source discards in-flight responses on redirect_valid; the aligner does not track them.
- Reset asserted mid-operation clears the buffer immediately, with no output pulse.
- Stall: while dec_valid && !dec_ready, dec_instr, dec_raw, dec_pc and dec_compressed hold stable.
- fetch_addr and pc wrap modulo 2^32 with no special handling.

Decomposition:
- common_pkg gains:
  - typedef halfword_t (logic [15:0]);
  - constant OPC_UNCOMPRESSED = 2'b11;
  - function is_compressed(halfword_t).
- instruction_t is reused from common_pkg.
- One sub-module: the existing decompressor, instantiated on dec_raw.
- All buffer, PC and handshake logic lives in fetch_aligner.

Test Plan:
- Reset, RESET_PC=0, word 0x00A00093 at addr 0 → dec_pc=0, dec_compressed=0, dec_instr=0x00A00093, one cycle after accept; next fetch_addr=4.
- Word 0x45894505 → two outputs: pc 0 with dec_raw=0x00004505 and dec_instr=0x00100513; then pc 2 with dec_raw=0x00004589 and dec_instr=0x00200593.
- Straddle: words 0x00934505 then 0x458900A0:
  - pc 0 c.li (0x00100513);
  - pc 2 dec_raw=0x00A00093, emitted only after the second word;
  - pc 6 c.li a1,2.
- Back-to-back 32-bit words with dec_ready=1 → fetch_ready stays 1 and one instruction per cycle; drop dec_ready for 3 cycles → outputs hold, fetch_ready=0 once count would reach 2.
- redirect_pc=0x102 with a 32-bit instruction pending → fetch_addr=0x100, pending instruction dropped; word 0x45058067 yields only pc 0x102 c.li a0,1.
- reset_n low while count=3 → dec_valid=0 immediately; after release pc=RESET_PC and fetch_addr=RESET_PC.
